ma_lsu: RTL and testbench

MA_LSU -- requirements
Module: ma_lsu

---
 rtl/ma_lsu_pkg.sv | 48 ++++
 rtl/ma_lsu_if.sv | 23 ++
 rtl/ma_load_align.sv | 32 +++
 rtl/ma_lsu.sv | 152 +++++++++++++++
 tb/tb_ma_lsu.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ma_lsu_pkg.sv
// Shared decode constants, FSM state type and store-formatting helpers for the MA-stage LSU.
package ma_lsu_pkg;

    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDone
    } lsu_state_e;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   byte_en = 4'b0001 << offset;
            2'b01:   byte_en = offset[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   store_data = {4{data[7:0]}};
            2'b01:   store_data = {2{data[15:0]}};
            default: store_data = data;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = offset[0];
            default: misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/ma_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface ma_lsu_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/ma_load_align.sv
// Selects the addressed byte/half from a memory word and sign- or zero-extends it.
module ma_load_align
    import ma_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        unique case (offset)
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
        endcase
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3Lb:    result = {{24{w_byte[7]}}, w_byte};
            F3Lbu:   result = {24'h0, w_byte};
            F3Lh:    result = {{16{w_half[15]}}, w_half};
            F3Lhu:   result = {16'h0, w_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/ma_lsu.sv
// MA-stage load/store unit: decodes the MA instruction, runs one memory transaction per
// access and stalls the pipeline until the access completes.
module ma_lsu
    import ma_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_m,
    input  logic [31:0] Instr_M,
    input  logic [31:0] ALU_Result_M,
    input  logic [31:0] Write_Data_M,
    output logic [31:0] Read_Data_M,
    output logic        stall_m,
    output logic        misalign_m,
    ma_lsu_if.master    mem
);

    lsu_state_e  r_state, w_state_d;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [31:0] r_rdata;
    logic        r_misalign;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [1:0]  w_size;
    logic [1:0]  w_offset;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_access;
    logic        w_misalign;
    logic        w_stall;
    logic        w_capture;
    logic        w_misalign_hit;
    logic        w_load_done;
    logic        w_req;
    logic [31:0] w_load_data;
    logic        w_unused_instr;

    assign w_opcode       = Instr_M[6:0];
    assign w_funct3       = Instr_M[14:12];
    assign w_size         = w_funct3[1:0];
    assign w_offset       = ALU_Result_M[1:0];
    assign w_unused_instr = ^{Instr_M[31:15], Instr_M[11:7]};

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        if (w_opcode == OpcLoad) begin
            w_is_load = w_funct3 inside {F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu};
        end else if (w_opcode == OpcStore) begin
            w_is_store = w_funct3 inside {F3Sb, F3Sh, F3Sw};
        end
    end

    assign w_access   = valid_m & (w_is_load | w_is_store);
    assign w_misalign = misaligned(w_size, w_offset);

    always_comb begin
        w_state_d      = r_state;
        w_stall        = 1'b0;
        w_capture      = 1'b0;
        w_misalign_hit = 1'b0;
        w_load_done    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_access) begin
                    if (w_misalign) begin
                        w_misalign_hit = 1'b1;
                    end else begin
                        w_stall   = 1'b1;
                        w_capture = 1'b1;
                        w_state_d = StReq;
                    end
                end
            end
            StReq: begin
                w_stall = 1'b1;
                if (mem.mem_gnt) begin
                    w_state_d = r_we ? StDone : StResp;
                end
            end
            StResp: begin
                w_stall = 1'b1;
                if (mem.mem_rvalid) begin
                    w_load_done = 1'b1;
                    w_state_d   = StDone;
                end
            end
            // The finished instruction leaves MA on this edge; never re-decode it here.
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_be       <= 4'h0;
            r_wdata    <= 32'h0;
            r_funct3   <= 3'h0;
            r_offset   <= 2'h0;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_misalign <= w_misalign_hit;
            if (w_misalign_hit) begin
                r_rdata <= 32'h0;
            end else if (w_load_done) begin
                r_rdata <= w_load_data;
            end
            if (w_capture) begin
                r_we     <= w_is_store;
                r_addr   <= {ALU_Result_M[31:2], 2'b00};
                r_be     <= byte_en(w_size, w_offset);
                r_wdata  <= store_data(w_size, Write_Data_M);
                r_funct3 <= w_funct3;
                r_offset <= w_offset;
            end
        end
    end

    ma_load_align u_load_align (
        .rdata  (mem.mem_rdata),
        .funct3 (r_funct3),
        .offset (r_offset),
        .result (w_load_data)
    );

    assign w_req         = (r_state == StReq);
    assign mem.mem_req   = w_req;
    assign mem.mem_we    = w_req & r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;

    assign Read_Data_M = r_rdata;
    assign stall_m     = w_stall;
    assign misalign_m  = r_misalign;

endmodule

// File: tb/tb_ma_lsu.sv
// Scoreboard bench for ma_lsu: stimulus pushes hand-computed expectations, monitors pop and
// compare on memory grants, stall releases and misalign pulses.
module tb_ma_lsu;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } req_t;

    typedef struct {
        int          stall;
        logic [31:0] data;
    } done_t;

    typedef struct {
        int          len;
        logic [31:0] data;
    } mis_t;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_m = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] alu = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic [31:0] rd;
    logic        stall;
    logic        mis;

    int n_checks = 0;
    int n_err = 0;

    req_t  req_q[$];
    done_t done_q[$];
    mis_t  mis_q[$];

    int          gnt_delay = 0;
    int          rsp_delay = 0;
    logic [31:0] rsp_data = 32'h0;

    ma_lsu_if mif ();

    ma_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .valid_m      (valid_m),
        .Instr_M      (instr),
        .ALU_Result_M (alu),
        .Write_Data_M (wdat),
        .Read_Data_M  (rd),
        .stall_m      (stall),
        .misalign_m   (mis),
        .mem          (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
        return {17'h0, f3, 5'd3, opc};
    endfunction

    task automatic exp_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int len);
        req_q.push_back('{we, addr, be, wdata, len});
    endtask

    task automatic exp_done(input int st, input logic [31:0] data);
        done_q.push_back('{st, data});
    endtask

    // Present an instruction in MA and keep it there until the LSU releases the stall.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data);
        bit released = 1'b0;
        valid_m = 1'b1;
        instr   = mk(opc, f3);
        alu     = addr;
        wdat    = data;
        for (int i = 0; i < 40 && !released; i++) begin
            @(negedge clk);
            released = !stall;
        end
        if (!released) fail_evt("stall_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        valid_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Memory responder
    initial begin
        int  wait_n = 0;
        int  rwait = 0;
        bit  pend = 1'b0;
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mif.mem_gnt    = 1'b0;
            mif.mem_rvalid = 1'b0;
            if (pend) begin
                if (rwait >= rsp_delay) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata  = rsp_data;
                    pend = 1'b0;
                end else begin
                    rwait++;
                end
            end else if (mif.mem_req) begin
                if (wait_n >= gnt_delay) begin
                    mif.mem_gnt = 1'b1;
                    wait_n = 0;
                    if (!mif.mem_we) begin
                        pend  = 1'b1;
                        rwait = 0;
                    end
                end else begin
                    wait_n++;
                end
            end
        end
    end

    // Request monitor
    initial begin
        int   run = 0;
        req_t e;
        forever begin
            @(negedge clk);
            if (!rst) chk("we_without_req", 32'(mif.mem_we & ~mif.mem_req), 32'h0);
            if (mif.mem_req === 1'b1) begin
                run++;
                if (mif.mem_gnt) begin
                    if (req_q.size() == 0) begin
                        fail_evt("unexpected_request");
                    end else begin
                        e = req_q.pop_front();
                        chk("req_we", 32'(mif.mem_we), 32'(e.we));
                        chk("req_addr", mif.mem_addr, e.addr);
                        chk("req_be", 32'(mif.mem_be), 32'(e.be));
                        if (e.we) chk("req_wdata", mif.mem_wdata, e.wdata);
                        chk("req_cycles", 32'(run), 32'(e.len));
                    end
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
    end

    // Stall-release monitor
    initial begin
        int    run = 0;
        done_t e;
        forever begin
            @(negedge clk);
            if (stall === 1'b1) begin
                run++;
            end else if (run > 0) begin
                if (done_q.size() == 0) begin
                    fail_evt("unexpected_release");
                end else begin
                    e = done_q.pop_front();
                    chk("stall_cycles", 32'(run), 32'(e.stall));
                    chk("read_data", rd, e.data);
                end
                run = 0;
            end
        end
    end

    // Misalign pulse monitor
    initial begin
        int          run = 0;
        logic [31:0] rd_at = 32'h0;
        mis_t        e;
        forever begin
            @(negedge clk);
            if (mis === 1'b1) begin
                if (run == 0) rd_at = rd;
                run++;
                chk("misalign_no_req", 32'(mif.mem_req), 32'h0);
            end else if (run > 0) begin
                if (mis_q.size() == 0) begin
                    fail_evt("unexpected_misalign");
                end else begin
                    e = mis_q.pop_front();
                    chk("misalign_len", 32'(run), 32'(e.len));
                    chk("misalign_rd", rd_at, e.data);
                end
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_data", rd, 32'h0);
        chk("rst_misalign", 32'(mis), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_req", 32'(mif.mem_req), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // lw, gnt immediate, rvalid next cycle
        rsp_data = 32'hDEADBEEF;
        exp_req(1'b0, 32'h100, 4'b1111, 32'h0, 1);
        exp_done(3, 32'hDEADBEEF);
        issue(LOAD, 3'b010, 32'h103 - 32'h3, 32'h0);

        rsp_data = 32'h80000000;
        exp_req(1'b0, 32'h100, 4'b1000, 32'h0, 1);
        exp_done(3, 32'hFFFFFF80);
        issue(LOAD, 3'b000, 32'h103, 32'h0);

        exp_req(1'b0, 32'h100, 4'b1000, 32'h0, 1);
        exp_done(3, 32'h00000080);
        issue(LOAD, 3'b100, 32'h103, 32'h0);

        rsp_data = 32'h80010000;
        exp_req(1'b0, 32'h100, 4'b1100, 32'h0, 1);
        exp_done(3, 32'hFFFF8001);
        issue(LOAD, 3'b001, 32'h102, 32'h0);

        exp_req(1'b0, 32'h100, 4'b1100, 32'h0, 1);
        exp_done(3, 32'h00008001);
        issue(LOAD, 3'b101, 32'h102, 32'h0);

        // sh with grant delayed two cycles
        gnt_delay = 2;
        exp_req(1'b1, 32'h100, 4'b1100, 32'hABCDABCD, 3);
        exp_done(4, 32'h00008001);
        issue(STORE, 3'b001, 32'h102, 32'h0000ABCD);
        gnt_delay = 0;

        exp_req(1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5, 1);
        exp_done(2, 32'h00008001);
        issue(STORE, 3'b000, 32'h201, 32'h000000A5);

        // Non-access instruction: no request, no stall
        issue(ALU, 3'b000, 32'h100, 32'h0);
        idle_cycle();

        // Reset while waiting for rvalid; rvalid then arrives two cycles later
        rsp_delay = 2;
        rsp_data  = 32'h12345678;
        exp_req(1'b0, 32'h300, 4'b1111, 32'h0, 1);
        exp_done(3, 32'h0);
        valid_m = 1'b1;
        instr   = mk(LOAD, 3'b010);
        alu     = 32'h300;
        wdat    = 32'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("resp_stall", 32'(stall), 32'h1);
        chk("resp_no_req", 32'(mif.mem_req), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        valid_m = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abandon_read_data", rd, 32'h0);
        chk("abandon_stall", 32'(stall), 32'h0);
        chk("abandon_req", 32'(mif.mem_req), 32'h0);
        rsp_delay = 0;

        rsp_data = 32'hCAFEF00D;
        exp_req(1'b0, 32'h104, 4'b1111, 32'h0, 1);
        exp_done(3, 32'hCAFEF00D);
        issue(LOAD, 3'b010, 32'h104, 32'h0);
        idle_cycle();

        // Misaligned accesses: no request, one-cycle pulse, result cleared
        mis_q.push_back('{1, 32'h0});
        issue(LOAD, 3'b010, 32'h101, 32'h0);
        idle_cycle();
        idle_cycle();
        mis_q.push_back('{1, 32'h0});
        issue(STORE, 3'b001, 32'h103, 32'h1234);
        idle_cycle();
        idle_cycle();

        // Back-to-back sw then lw to the same word
        rsp_data = 32'h11223344;
        exp_req(1'b1, 32'h200, 4'b1111, 32'h11223344, 1);
        exp_done(2, 32'h0);
        exp_req(1'b0, 32'h200, 4'b1111, 32'h0, 1);
        exp_done(3, 32'h11223344);
        issue(STORE, 3'b010, 32'h200, 32'h11223344);
        issue(LOAD, 3'b010, 32'h200, 32'h0);
        valid_m = 1'b0;

        repeat (6) @(posedge clk);
        #1;
        chk("req_q_drained", 32'(req_q.size()), 32'h0);
        chk("done_q_drained", 32'(done_q.size()), 32'h0);
        chk("mis_q_drained", 32'(mis_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
